// File: rtl/md_scheduler.sv
// rtl/md_scheduler.sv - multi-cycle multiply/divide unit holding HI/LO, with busy and stall request
// Results are computed at accept time into staging registers and committed after the busy window.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_req
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] stage_hi_q, stage_hi_d;
  logic [31:0] stage_lo_q, stage_lo_d;
  logic        commit_q, commit_d;
  logic        busy_q, busy_d;

  logic               is_long;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               a_neg, b_neg;
  logic [31:0]        a_mag, b_mag;
  logic [31:0]        uq, ur;
  logic [31:0]        quot, rem;

  assign is_long = start && (md_op >= 3'd1) && (md_op <= 3'd4);

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide runs on magnitudes; the quotient sign is the XOR, remainder follows the dividend.
  always_comb begin
    a_neg = (md_op == 3'd3) && A[31];
    b_neg = (md_op == 3'd3) && B[31];
    a_mag = a_neg ? (~A + 32'd1) : A;
    b_mag = b_neg ? (~B + 32'd1) : B;
    uq    = 32'd0;
    ur    = 32'd0;
    if (b_mag != 32'd0) begin
      uq = a_mag / b_mag;
      ur = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    rem  = a_neg ? (~ur + 32'd1) : ur;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    stage_hi_d = stage_hi_q;
    stage_lo_d = stage_lo_q;
    commit_d   = commit_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            3'd1, 3'd2: begin
              stage_hi_d = (md_op == 3'd1) ? prod_s[63:32] : prod_u[63:32];
              stage_lo_d = (md_op == 3'd1) ? prod_s[31:0]  : prod_u[31:0];
              commit_d   = 1'b1;
              cnt_d      = MULT_LOAD;
              state_d    = ST_RUN;
              busy_d     = 1'b1;
            end
            3'd3, 3'd4: begin
              stage_hi_d = rem;
              stage_lo_d = quot;
              // Divide by zero still occupies the unit but leaves HI/LO untouched.
              commit_d   = (B != 32'd0);
              cnt_d      = DIV_LOAD;
              state_d    = ST_RUN;
              busy_d     = 1'b1;
            end
            3'd5:    hi_d = A;
            3'd6:    lo_d = A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == 5'd0) begin
          if (commit_q) begin
            hi_d = stage_hi_q;
            lo_d = stage_lo_q;
          end
          commit_d = 1'b0;
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      stage_hi_q <= 32'd0;
      stage_lo_q <= 32'd0;
      commit_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      stage_hi_q <= stage_hi_d;
      stage_lo_q <= stage_lo_d;
      commit_q   <= commit_d;
      busy_q     <= busy_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign stall_req = md_use & (busy_q | is_long);

endmodule

// File: tb/tb_md_scheduler.sv
// tb/tb_md_scheduler.sv - directed plus random checks of md_scheduler against a behavioural HI/LO model
module tb_md_scheduler;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_use;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_req;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .md_op     (md_op),
    .A         (A),
    .B         (B),
    .md_use    (md_use),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall_req (stall_req)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one command issued from idle: new HI/LO and number of busy cycles.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nh, output logic [31:0] nl, output int n);
    longint          sp;
    longint unsigned up;
    nh = m_hi;
    nl = m_lo;
    n  = 0;
    case (op)
      3'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        nh = sp[63:32]; nl = sp[31:0]; n = MC;
      end
      3'd2: begin
        up = 64'(a) * 64'(b);
        nh = up[63:32]; nl = up[31:0]; n = MC;
      end
      3'd3: begin
        n = DC;
        if (b != 32'd0) begin
          sp = longint'($signed(a)) / longint'($signed(b));
          nl = sp[31:0];
          sp = longint'($signed(a)) % longint'($signed(b));
          nh = sp[31:0];
        end
      end
      3'd4: begin
        n = DC;
        if (b != 32'd0) begin
          nl = a / b;
          nh = a % b;
        end
      end
      3'd5: nh = a;
      3'd6: nl = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_i, input bit inj, input string tag);
    logic [31:0] eh, el, oh, ol;
    int          n, cnt;
    model(op, a, b, eh, el, n);
    oh = m_hi;
    ol = m_lo;
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b; md_use = use_i;
    #1 check({tag, ".stall_accept"}, 32'(stall_req), 32'(use_i && op >= 3'd1 && op <= 3'd4));
    @(posedge clk);
    #1 start = 1'b0; md_op = 3'd0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      check({tag, ".hi_hold"}, hi, oh);
      check({tag, ".lo_hold"}, lo, ol);
      check({tag, ".stall_run"}, 32'(stall_req), 32'(use_i));
      if (inj && cnt == 2) begin
        start = 1'b1; md_op = 3'($urandom_range(1, 6)); A = $urandom; B = $urandom;
      end else begin
        start = 1'b0; md_op = 3'd0;
      end
    end
    start = 1'b0;
    check({tag, ".busy_cycles"}, 32'(cnt), 32'(n));
    check({tag, ".hi"}, hi, eh);
    check({tag, ".lo"}, lo, el);
    check({tag, ".stall_done"}, 32'(stall_req), 32'd0);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset_n = 1'b0; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0; md_use = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.hi", hi, 32'd0);
    check("reset.lo", lo, 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    run_op(3'd5, 32'h55, 32'd0, 1'b0, 1'b0, "pre_mthi");
    run_op(3'd6, 32'h66, 32'd0, 1'b0, 1'b0, "pre_mtlo");

    // Asynchronous reset in the second busy cycle must discard the pending product.
    @(negedge clk);
    start = 1'b1; md_op = 3'd1; A = 32'd3; B = 32'd4;
    @(posedge clk);
    #1 start = 1'b0; md_op = 3'd0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid.hi", hi, 32'd0);
    check("rst_mid.lo", lo, 32'd0);
    check("rst_mid.busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (12) @(negedge clk);
    check("rst_after.hi", hi, 32'd0);
    check("rst_after.lo", lo, 32'd0);
    check("rst_after.busy", 32'(busy), 32'd0);

    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, "mult");
    run_op(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, "multu");
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, "div");
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "div_ovf");
    run_op(3'd5, 32'h11, 32'd0, 1'b0, 1'b0, "mthi11");
    run_op(3'd6, 32'h22, 32'd0, 1'b0, 1'b0, "mtlo22");
    run_op(3'd4, 32'h1234, 32'd0, 1'b0, 1'b0, "divu0");
    run_op(3'd5, 32'hABCD, 32'd0, 1'b0, 1'b0, "mthi");
    run_op(3'd1, $urandom, $urandom, 1'b1, 1'b0, "mult_use");
    run_op(3'd1, 32'd7, 32'd9, 1'b1, 1'b1, "inject");
    run_op(3'd0, 32'h99, 32'h99, 1'b1, 1'b0, "op_none");
    run_op(3'd7, 32'h99, 32'h99, 1'b1, 1'b0, "op_rsvd");

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)),
             (rop >= 3'd1 && rop <= 3'd4 && $urandom_range(0, 3) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
